// File: rtl/muldiv_unit_pkg.sv
// Op encodings and FSM states shared by the multiply/divide unit and its bus interface.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bus of the multiply/divide unit; the controller is the master.
interface muldiv_unit_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(parameter int unsigned W = 32) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit with HI/LO registers; WIDTH+1 cycles per mul/div, MTHI/MTLO in one.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they execute as MULTU/DIVU.
import muldiv_pkg::*;

module muldiv_unit #(parameter int unsigned WIDTH = 32) (
  input logic          Clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 div_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_res_q;
  logic neg_rem_q;

  assign neg_a = bus.op[0] & bus.a[WIDTH-1];
  assign neg_b = bus.op[0] & bus.b[WIDTH-1];

  cond_negate #(.W(WIDTH))   u_mag_a    (.x(bus.a),                   .neg(neg_a),     .y(mag_a));
  cond_negate #(.W(WIDTH))   u_mag_b    (.x(bus.b),                   .neg(neg_b),     .y(mag_b));
  cond_negate #(.W(2*WIDTH)) u_fix_prod (.x(acc_q),                   .neg(neg_res_q), .y(prod_fix));
  cond_negate #(.W(WIDTH))   u_fix_quo  (.x(acc_q[WIDTH-1:0]),        .neg(neg_res_q), .y(quo_fix));
  cond_negate #(.W(WIDTH))   u_fix_rem  (.x(acc_q[2*WIDTH-1:WIDTH]),  .neg(neg_rem_q), .y(rem_fix));
`else
  assign mag_a    = bus.a;
  assign mag_b    = bus.b;
  assign prod_fix = acc_q;
  assign quo_fix  = acc_q[WIDTH-1:0];
  assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    addend    = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    result = div_q ? {rem_fix, quo_fix} : prod_fix;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              div_q   <= bus.op[1];
              acc_q   <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
              opnd_q  <= bus.op[1] ? mag_b : mag_a;
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
`ifdef MULDIV_SIGNED_EN
              neg_res_q <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
`endif
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FIN;
        end
        ST_FIN: begin
          hi_q    <= result[2*WIDTH-1:WIDTH];
          lo_q    <= (div_q && opnd_q == '0) ? '1 : result[WIDTH-1:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
